// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte arbiter and FIFO that feeds a UART TX
// serialiser through a start/busy handshake, with sticky done/error flags.
// Ports:
//   clock, nRst              clock, async active-low reset
//   req, req_data, gnt       requester byte offers and one-hot combinational grant
//   tx_start, tx_byte        one-cycle launch pulse and byte held for the frame
//   tx_busy                  serialiser frame in progress
//   irq_clr, irq, ack_err    sticky drained / no-ack flags and their clear
//   fifo_count               current FIFO occupancy
module uart_tx_sched #(
    parameter int NREQ        = 2,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       nRst,
    input  logic [NREQ-1:0]            req,
    input  logic [8*NREQ-1:0]          req_data,
    output logic [NREQ-1:0]            gnt,
    output logic                       tx_start,
    output logic [7:0]                 tx_byte,
    input  logic                       tx_busy,
    input  logic                       irq_clr,
    output logic                       irq,
    output logic                       ack_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [RW-1:0] rr_last;
    logic [RW-1:0] gidx;
    logic [RW-1:0] cand;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic [7:0]    push_data;
    logic [7:0]    byte_n;
    logic          full;
    logic          push;
    logic          pop;
    logic          hit;
    logic          start_n;
    logic          irq_set;
    logic          err_set;

    // Fullness uses the registered count, so a pop this cycle
    // cannot open a slot for a grant in the same cycle.
    assign full = (fifo_count == CW'(DEPTH));

    // Scan from the requester after the last winner, wrapping.
    always_comb begin
        gnt  = '0;
        gidx = rr_last;
        cand = rr_last;
        hit  = 1'b0;
        if (!full) begin
            for (int i = 1; i <= NREQ; i++) begin
                cand = RW'((int'(rr_last) + i) % NREQ);
                if (!hit && req[cand]) begin
                    hit  = 1'b1;
                    gidx = cand;
                end
            end
        end
        if (hit) gnt[gidx] = 1'b1;
    end

    assign push = hit;

    always_comb begin
        push_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) push_data = req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        start_n = 1'b0;
        byte_n  = tx_byte;
        timer_n = timer;
        irq_set = 1'b0;
        err_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0 && !tx_busy) begin
                    pop     = 1'b1;
                    start_n = 1'b1;
                    byte_n  = mem[rd_ptr];
                    timer_n = '0;
                    state_n = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (timer == TW'(ACK_TIMEOUT)) begin
                    // Byte is abandoned; no retry.
                    err_set = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_n = IDLE;
                    irq_set = (fifo_count == '0) && !push;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rr_last    <= RW'(NREQ - 1);
            timer      <= '0;
            tx_start   <= 1'b0;
            tx_byte    <= 8'h00;
            irq        <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            tx_start <= start_n;
            tx_byte  <= byte_n;
            // A set in the same cycle wins over the clear.
            irq      <= irq_set | (irq & ~irq_clr);
            ack_err  <= err_set | (ack_err & ~irq_clr);
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                rr_last <= gidx;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched with a serialiser
// model, directed scenarios and a randomized traffic phase.
module tb_uart_tx_sched;

    localparam int NREQ        = 2;
    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              nRst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   gnt;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic              irq_clr;
    logic              irq;
    logic              ack_err;
    logic [3:0]        fifo_count;

    logic irq_clr_tb = 1'b0;
    logic irq_clr_ser = 1'b0;
    logic busy_s = 1'b0;
    logic ser_force = 1'b0;

    assign tx_busy = busy_s | ser_force;
    assign irq_clr = irq_clr_tb | irq_clr_ser;

    uart_tx_sched #(
        .NREQ(NREQ),
        .DEPTH(DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clock(clock),
        .nRst(nRst),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .tx_start(tx_start),
        .tx_byte(tx_byte),
        .tx_busy(tx_busy),
        .irq_clr(irq_clr),
        .irq(irq),
        .ack_err(ack_err),
        .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: occupancy, round-robin pointer and expected byte order.
    logic [7:0]      exp_q[$];
    logic [7:0]      tx_log[$];
    int              start_q[$];
    int              m_cnt = 0;
    int              m_rr = NREQ - 1;
    bit              m_pend = 0;
    logic [NREQ-1:0] gnt_seen = '0;

    always @(negedge clock) begin
        logic [NREQ-1:0] eg;
        int w;
        int sel;
        if (!nRst) begin
            m_cnt = 0;
            m_rr = NREQ - 1;
            m_pend = 0;
            exp_q.delete();
            gnt_seen = '0;
        end else begin
            if (m_pend) m_cnt++;
            if (tx_start) m_cnt--;
            m_pend = 0;
            chk("fifo_count", fifo_count, m_cnt);
            eg = '0;
            sel = -1;
            if (m_cnt < DEPTH) begin
                for (int k = 1; k <= NREQ; k++) begin
                    w = (m_rr + k) % NREQ;
                    if (sel < 0 && req[w]) sel = w;
                end
            end
            if (sel >= 0) eg[sel] = 1'b1;
            chk("gnt", gnt, eg);
            if (sel >= 0) begin
                exp_q.push_back(req_data[8*sel +: 8]);
                m_rr = sel;
                m_pend = 1;
            end
            gnt_seen = gnt;
        end
    end

    // Monitor: every launch must carry the oldest accepted byte.
    logic [7:0] cur_byte = 8'h00;
    logic       busy_prev = 1'b0;

    always @(negedge clock) begin
        logic [7:0] e;
        if (!nRst) begin
            cur_byte = 8'h00;
            busy_prev = 1'b0;
        end else begin
            if (tx_start) begin
                chk("start_while_idle", busy_prev, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got byte %0h expected none", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", tx_byte, e);
                    cur_byte = e;
                end
                tx_log.push_back(tx_byte);
                start_q.push_back(cyc);
            end else if (tx_busy) begin
                chk("tx_byte_hold", tx_byte, cur_byte);
            end
            busy_prev = tx_busy;
        end
    end

    // Serialiser model: optional ack delay, then busy for a frame length.
    int ser_dmin = 0;
    int ser_dmax = 0;
    int ser_lmin = 4;
    int ser_lmax = 4;
    bit ser_noack = 0;
    bit ser_clr_fall = 0;

    initial begin : ser
        int s_wait;
        int s_len;
        bit st;
        s_wait = -1;
        s_len = 0;
        forever begin
            @(negedge clock);
            st = nRst && tx_start;
            @(posedge clock);
            #1;
            irq_clr_ser = 1'b0;
            if (!nRst) begin
                s_wait = -1;
                s_len = 0;
                busy_s = 1'b0;
            end else begin
                if (st && !ser_noack) s_wait = int'($urandom_range(ser_dmax, ser_dmin));
                if (s_wait == 0) begin
                    busy_s = 1'b1;
                    s_len = int'($urandom_range(ser_lmax, ser_lmin));
                    s_wait = -1;
                end else if (s_wait > 0) begin
                    s_wait--;
                end else if (busy_s) begin
                    s_len--;
                    if (s_len == 0) begin
                        busy_s = 1'b0;
                        irq_clr_ser = ser_clr_fall;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(int r, logic [7:0] b, output int gc);
        int n;
        bit got;
        tick();
        req[r] = 1'b1;
        req_data[8*r +: 8] = b;
        got = 0;
        n = 0;
        gc = 0;
        while (!got && n < 50) begin
            @(negedge clock);
            if (gnt[r]) begin
                got = 1;
                gc = cyc;
            end
            n++;
        end
        chk("send_granted", got, 1);
        tick();
        req[r] = 1'b0;
    endtask

    task automatic wait_busy(bit lvl, int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (tx_busy !== lvl && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("wait_busy", tx_busy, lvl);
    endtask

    task automatic wait_starts(int cnt, int budget);
        int n;
        n = 0;
        while (start_q.size() < cnt && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("start_count", start_q.size(), cnt);
    endtask

    task automatic wait_quiet(int budget);
        int n;
        int q;
        n = 0;
        q = 0;
        while (q < 20 && n < budget) begin
            @(negedge clock);
            if (!tx_busy && !tx_start && fifo_count == 0 && exp_q.size() == 0) q++;
            else q = 0;
            n++;
        end
        chk("drain", q, 20);
    endtask

    task automatic pulse_clr();
        tick();
        irq_clr_tb = 1'b1;
        tick();
        irq_clr_tb = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int g;
        int s1;
        int s2;
        int e;
        int k;
        int n;
        int cnt;
        logic [NREQ-1:0] gl [4];
        logic [NREQ-1:0] gs;

        repeat (3) @(negedge clock);
        chk("rst_gnt", gnt, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_fifo_count", fifo_count, 0);
        nRst = 1'b1;
        repeat (2) @(negedge clock);

        // Single byte, long frame.
        ser_dmin = 0; ser_dmax = 0; ser_lmin = 100; ser_lmax = 100;
        start_q.delete();
        tx_log.delete();
        send(0, 8'h0A, g);
        wait_starts(1, 20);
        if (start_q.size() > 0) chk("latency", start_q[0] - g, 2);
        if (tx_log.size() > 0) chk("single_byte", tx_log[0], 8'h0A);
        wait_busy(1, 20);
        wait_busy(0, 200);
        chk("irq_before", irq, 0);
        @(negedge clock);
        chk("irq_after_fall", irq, 1);
        chk("single_count", fifo_count, 0);

        // Leave requester 1 as last winner so requester 0 leads next.
        ser_lmin = 3; ser_lmax = 3; ser_dmin = 1; ser_dmax = 1;
        send(1, 8'h5A, g);
        wait_quiet(500);
        pulse_clr();
        chk("irq_cleared", irq, 0);

        // Round-robin with both requesters held.
        tx_log.delete();
        tick();
        req_data = {8'h22, 8'h11};
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            gl[i] = gnt;
            tick();
        end
        req = '0;
        chk("rr_0", gl[0], 2'b01);
        chk("rr_1", gl[1], 2'b10);
        chk("rr_2", gl[2], 2'b01);
        chk("rr_3", gl[3], 2'b10);
        wait_quiet(500);
        chk("rr_tx_count", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            chk("rr_tx0", tx_log[0], 8'h11);
            chk("rr_tx1", tx_log[1], 8'h22);
            chk("rr_tx2", tx_log[2], 8'h11);
            chk("rr_tx3", tx_log[3], 8'h22);
        end

        // Full FIFO with the serialiser stuck busy.
        tx_log.delete();
        tick();
        ser_force = 1'b1;
        k = 0;
        cnt = 0;
        req_data[7:0] = 8'h30;
        req[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (gnt[0]) begin
                cnt++;
                k++;
            end
            tick();
            req_data[7:0] = 8'(8'h30 + k);
        end
        chk("full_gnt_pulses", cnt, 8);
        @(negedge clock);
        chk("full_count", fifo_count, 8);
        chk("full_no_gnt", gnt, 0);
        tick();
        ser_force = 1'b0;
        n = 0;
        while (k < 10 && n < 200) begin
            @(negedge clock);
            if (gnt[0]) k++;
            tick();
            req_data[7:0] = 8'(8'h30 + k);
            if (k == 10) req[0] = 1'b0;
            n++;
        end
        req[0] = 1'b0;
        chk("full_resume", k, 10);
        wait_quiet(1000);
        chk("full_tx_count", tx_log.size(), 10);
        if (tx_log.size() == 10) begin
            chk("full_tx_first", tx_log[0], 8'h30);
            chk("full_tx_last", tx_log[9], 8'h39);
        end

        // Serialiser never acknowledges.
        ser_noack = 1;
        tx_log.delete();
        start_q.delete();
        tick();
        req_data = {8'hA2, 8'hA1};
        req = 2'b11;
        n = 0;
        while (req != 0 && n < 20) begin
            @(negedge clock);
            gs = gnt;
            tick();
            req = req & ~gs;
            n++;
        end
        wait_starts(1, 20);
        s1 = (start_q.size() > 0) ? start_q[0] : 0;
        e = 0;
        n = 0;
        while (ack_err !== 1'b1 && n < 60) begin
            @(negedge clock);
            e = cyc;
            n++;
        end
        chk("ack_err_set", ack_err, 1);
        chk("ack_err_delay", e - s1, ACK_TIMEOUT + 1);
        wait_starts(2, 40);
        s2 = (start_q.size() > 1) ? start_q[1] : 0;
        chk("next_launch", s2 - s1, ACK_TIMEOUT + 2);
        wait_quiet(200);
        chk("noack_tx_count", tx_log.size(), 2);
        pulse_clr();
        chk("ack_err_cleared", ack_err, 0);
        chk("irq_after_noack", irq, 0);
        ser_noack = 0;

        // Clear arriving on the same edge as the irq set.
        ser_lmin = 5; ser_lmax = 5;
        ser_clr_fall = 1;
        send(0, 8'h55, g);
        wait_busy(1, 30);
        wait_busy(0, 30);
        @(negedge clock);
        chk("irq_set_beats_clr", irq, 1);
        ser_clr_fall = 0;
        pulse_clr();
        chk("irq_clr_alone", irq, 0);

        // Reset during a frame with bytes queued.
        ser_lmin = 60; ser_lmax = 60; ser_dmin = 0; ser_dmax = 0;
        tick();
        k = 0;
        req_data[7:0] = 8'hC0;
        req[0] = 1'b1;
        n = 0;
        while (k < 4 && n < 50) begin
            @(negedge clock);
            if (gnt[0]) k++;
            tick();
            req_data[7:0] = 8'(8'hC0 + k);
            if (k == 4) req[0] = 1'b0;
            n++;
        end
        req[0] = 1'b0;
        wait_busy(1, 20);
        repeat (3) @(negedge clock);
        chk("pre_reset_count", fifo_count, 3);
        @(negedge clock);
        nRst = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_tx_start", tx_start, 0);
        chk("mid_rst_tx_byte", tx_byte, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_ack_err", ack_err, 0);
        chk("mid_rst_count", fifo_count, 0);
        repeat (2) @(negedge clock);
        nRst = 1'b1;
        start_q.delete();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (tx_start) cnt++;
        end
        chk("no_start_after_reset", cnt, 0);
        ser_lmin = 3; ser_lmax = 3;
        tick();
        req_data = {8'hD1, 8'hD0};
        req = 2'b11;
        @(negedge clock);
        chk("rr_after_reset", gnt, 2'b01);
        n = 0;
        while (req != 0 && n < 20) begin
            gs = gnt;
            tick();
            req = req & ~gs;
            @(negedge clock);
            n++;
        end
        req = '0;
        wait_quiet(500);

        // Randomized traffic.
        pulse_clr();
        ser_dmin = 0; ser_dmax = 10; ser_lmin = 1; ser_lmax = 8;
        repeat (3000) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && gnt_seen[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
        tick();
        req = '0;
        wait_quiet(3000);
        chk("final_count", fifo_count, 0);
        chk("final_irq", irq, 1);
        chk("final_ack_err", ack_err, 0);
        chk("final_scoreboard", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Transmit scheduler in front of the UART TX serialiser.
- Collects bytes from NREQ requesters (CPU store path, debug/trace units) through a round-robin arbiter into a DEPTH-entry FIFO.
- Drains the FIFO one byte at a time into the serialiser using a start/busy handshake.
- Raises a sticky interrupt when the FIFO has fully drained, and a sticky error flag when the serialiser fails to acknowledge a start.

Parameters:
- NREQ, 2: number of byte requesters (≥1).
- DEPTH, 8: FIFO entries (power of two, ≥2).
- ACK_TIMEOUT, 15: cycles allowed between tx_start and tx_busy rising.

Ports:
- clock  in  1  system clock.
- nRst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester byte-valid.
- req_data  in  8*NREQ  requester i byte at [8i+7:8i].
- gnt  out  NREQ  one-hot; requester i's byte is accepted on this clock edge (combinational).
- tx_start  out  1  one-cycle pulse: serialiser must latch tx_byte and begin a frame.
- tx_byte  out  8  byte being sent, held stable from tx_start until the frame completes.
- tx_busy  in  1  serialiser frame in progress (start, data or stop bit).
- irq_clr  in  1  clears irq and ack_err.
- irq  out  1  sticky: transmission finished with FIFO empty.
- ack_err  out  1  sticky: tx_busy did not rise within ACK_TIMEOUT.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset values: gnt=0, tx_start=0, tx_byte=8'h00, irq=0, ack_err=0, fifo_count=0, state=IDLE, FIFO pointers=0, rr_last=NREQ-1 (requester 0 has first priority).
- Reset asserted mid-frame aborts immediately; FIFO contents are discarded.

Arbiter:
- When fifo_count<DEPTH, grant the first asserted req scanning from rr_last+1 upward, wrapping modulo NREQ. Assert that gnt bit in the same cycle.
- On the clock edge: push req_data of the granted requester and set rr_last to the granted index.
- When the FIFO is full: gnt=0 and rr_last is held. A pop in the same cycle does NOT enable a grant.
- A requester must hold req and its data until it sees gnt.

FIFO:
- Write and read pointers are log2(DEPTH) bits and wrap naturally.
- fifo_count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Push into an empty FIFO is visible to the FSM the next cycle; there is no bypass.

FSM:
- IDLE:
  - If fifo_count≠0 and tx_busy=0: pop the head into tx_byte, tx_start←1, timer←0, go to WAIT_BUSY.
  - Otherwise stay.
- WAIT_BUSY:
  - tx_start←0, so the pulse lasts exactly one cycle.
  - If tx_busy=1: go to WAIT_DONE.
  - Else if timer==ACK_TIMEOUT: ack_err←1, go to IDLE; the byte is dropped, not retried.
  - Else timer+1.
- WAIT_DONE:
  - When tx_busy=0: go to IDLE.
  - If, on that edge, fifo_count==0 and no push occurs, irq←1.
- Back-to-back bytes: IDLE re-launches on the cycle after the WAIT_DONE exit. Inter-frame gap is 1 idle clock plus the serialiser's stop bit.

Latency:
- req with an empty FIFO and an idle serialiser: gnt in cycle n, tx_start high in cycle n+2, tx_byte valid from cycle n+2.

irq / ack_err:
- Set has priority over irq_clr in the same cycle.
- irq_clr otherwise clears both flags on the next edge.

Test Plan:
- Single byte: req[0]=1, req_data=8'h0A, serialiser model busy for 100 cycles. Expect gnt[0] in cycle n, tx_start pulse in n+2 with tx_byte=0A, irq=1 one cycle after busy falls, fifo_count back to 0.
- Round-robin: req=2'b11 held with bytes 11/22 for 4 cycles. Expect grant order 0,1,0,1 and transmitted order 11,22,11,22.
- Full FIFO: DEPTH=8, busy held high, 10 pushes attempted. Expect exactly 8 gnt pulses, fifo_count=8, then gnt=0 until the first pop; all bytes go out in FIFO order.
- Ack timeout: serialiser model never asserts busy. Expect ack_err=1 exactly ACK_TIMEOUT+1 cycles after tx_start, FSM back in IDLE, the next byte launched, and irq_clr clearing ack_err.
- irq priority: irq_clr asserted on the same cycle irq would set. Expect irq=1; a second irq_clr with no set expects irq=0.
- Reset mid-frame: nRst low during WAIT_DONE with 3 bytes queued. Expect all outputs at reset values; after release, no tx_start until a new req arrives.
